tcam_adder_pipe: RTL and testbench

Parametrised, pipelined lookup-table adder/subtractor for the TCAM ALU datapath. Splits WIDTH-bit operands into SLICE-bit slices; each pipeline stage resolves one slice by table lookup indexed by {carry_in, a_slice, b_slice}, and registers the carry to the next stage. It generalises the fixed two-slice combinational ripple adder with configurable width and slice size, subtract mode, valid/ready flow control, and a runtime-programmable table.

---
 rtl/tcam_alu_pkg.sv | 16 +
 rtl/tcam_add_slice.sv | 50 +++++
 rtl/tcam_adder_pipe.sv | 91 +++++++++
 tb/tb_tcam_adder_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_alu_pkg.sv
// tcam_alu_pkg: shared types, default slice size and helpers for the TCAM adder pipeline.
package tcam_alu_pkg;
    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
    localparam int SLICE_DEF = 4;
    localparam int IDX_W_DEF = 2 * SLICE_DEF + 1;
    function automatic logic [IDX_W_DEF-1:0] tbl_index(
        input logic cin,
        input logic [SLICE_DEF-1:0] a_s,
        input logic [SLICE_DEF-1:0] b_s
    );
        return {cin, a_s, b_s};
    endfunction
    function automatic bit width_ok(input int width, input int slice);
        return slice > 0 && width % slice == 0;
    endfunction
endpackage

// File: rtl/tcam_add_slice.sv
// tcam_add_slice: one pipeline stage; resolves slice IDX of the beat through its own table copy.
import tcam_alu_pkg::*;
module tcam_add_slice #(
    parameter int WIDTH = 32,
    parameter int SLICE = SLICE_DEF,
    parameter int IDX = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr_en,
    input  logic [2*SLICE:0] wr_addr,
    input  logic [SLICE:0]   wr_data,
    input  logic             prev_valid,
    input  logic             prev_carry,
    input  logic [WIDTH-1:0] prev_a,
    input  logic [WIDTH-1:0] prev_b,
    output logic             valid,
    output logic             carry,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);
    localparam int DEPTH = 2 ** (2 * SLICE + 1);
    logic [SLICE:0]   tbl [DEPTH];
    logic [SLICE:0]   entry;
    logic [WIDTH-1:0] next_a;
    // Table is deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) tbl[wr_addr] <= wr_data;
    end
    assign entry = tbl[{prev_carry, prev_a[IDX*SLICE +: SLICE], prev_b[IDX*SLICE +: SLICE]}];
    // The resolved slice overwrites the consumed operand slice, so a carries the result upward.
    always_comb begin
        next_a = prev_a;
        next_a[IDX*SLICE +: SLICE] = entry[SLICE-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            carry <= 1'b0;
            a     <= '0;
            b     <= '0;
        end else if (en) begin
            valid <= prev_valid;
            carry <= entry[SLICE];
            a     <= next_a;
            b     <= prev_b;
        end
    end
endmodule

// File: rtl/tcam_adder_pipe.sv
// tcam_adder_pipe: pipelined table-lookup adder/subtractor, one SLICE-bit slice per stage.
// Define TCAM_ADD_CHECK_EN to add a native-adder reference path driving the sticky err flag.
import tcam_alu_pkg::*;
module tcam_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    input  logic             tbl_we,
    input  logic [2*SLICE:0] tbl_addr,
    input  logic [SLICE:0]   tbl_wdata,
    output logic             idle,
    output logic             err
);
    localparam int NSTG = WIDTH / SLICE;
    logic             valid_p [NSTG+1];
    logic             carry_p [NSTG+1];
    logic [WIDTH-1:0] a_p     [NSTG+1];
    logic [WIDTH-1:0] b_p     [NSTG+1];
    logic             advance;
    logic             tbl_wr;
    op_e              op;

    if (!width_ok(WIDTH, SLICE)) begin : g_bad_width
        $error("tcam_adder_pipe: WIDTH must be a multiple of SLICE");
    end

    assign op         = sub ? OP_SUB : OP_ADD;
    assign advance    = !(out_valid && !out_ready);
    assign in_ready   = advance && !tbl_we;
    assign tbl_wr     = tbl_we && idle;
    assign valid_p[0] = in_valid && in_ready;
    assign carry_p[0] = (op == OP_SUB);
    assign a_p[0]     = a;
    assign b_p[0]     = (op == OP_SUB) ? ~b : b;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        tcam_add_slice #(.WIDTH(WIDTH), .SLICE(SLICE), .IDX(k)) u_slice (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (advance),
            .wr_en      (tbl_wr),
            .wr_addr    (tbl_addr),
            .wr_data    (tbl_wdata),
            .prev_valid (valid_p[k]),
            .prev_carry (carry_p[k]),
            .prev_a     (a_p[k]),
            .prev_b     (b_p[k]),
            .valid      (valid_p[k+1]),
            .carry      (carry_p[k+1]),
            .a          (a_p[k+1]),
            .b          (b_p[k+1])
        );
    end

    assign out_valid = valid_p[NSTG];
    assign sum       = {carry_p[NSTG], a_p[NSTG]};

    always_comb begin
        idle = 1'b1;
        for (int i = 1; i <= NSTG; i++) if (valid_p[i]) idle = 1'b0;
    end

`ifdef TCAM_ADD_CHECK_EN
    // Reference results shift alongside the stage registers, bubbles included.
    logic [WIDTH:0] ref_p [NSTG];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTG; i++) ref_p[i] <= '0;
            err <= 1'b0;
        end else begin
            if (advance) begin
                ref_p[0] <= {1'b0, a} + {1'b0, b_p[0]} + (WIDTH+1)'(carry_p[0]);
                for (int i = 1; i < NSTG; i++) ref_p[i] <= ref_p[i-1];
            end
            if (out_valid && out_ready && ref_p[NSTG-1] != sum) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_tcam_adder_pipe.sv
// tb_tcam_adder_pipe: vector table plus scoreboard bench for tcam_adder_pipe (32-bit, 4-bit slices).
import tcam_alu_pkg::*;
module tb_tcam_adder_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] sum;
    logic        tbl_we;
    logic [8:0]  tbl_addr;
    logic [4:0]  tbl_wdata;
    logic        idle;
    logic        err;

`ifdef TCAM_ADD_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        logic [32:0] e;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [32:0] sb [$];
    bit          rand_rdy = 0;
    vec_t        vec [10];

    tcam_adder_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_wdata (tbl_wdata),
        .idle      (idle),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Every cycle with a result on offer is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
            else begin
                check("sb_sum", sum, sb[0]);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s, input logic [32:0] e);
        int n = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        sub = s;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1'b1);
        else sb.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while ((sb.size() != 0 || !idle) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_sb_empty", 33'(sb.size()), 33'd0);
        check("drain_idle", idle, 1'b1);
        tick();
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        int          n;
        vec[0] = '{32'h0000_0003, 32'h0000_0004, 1'b0, 33'h0_0000_0007};
        vec[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000};
        vec[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 33'h0_FFFF_FFFE};
        vec[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 33'h1_0000_0002};
        vec[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000};
        vec[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 33'h1_0000_0000};
        vec[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000};
        vec[7] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789};
        vec[8] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 33'h0_FFFF_FFFF};
        vec[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33'h1_FFFF_FFFE};
        in_valid = 0; a = 0; b = 0; sub = 0; out_ready = 1;
        tbl_we = 0; tbl_addr = 0; tbl_wdata = 0; rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_idle", idle, 1'b1);
        check("rst_sum", sum, 33'd0);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        tick();
        // Load the complete correct table: 4-bit slice add with carry.
        tbl_we = 1;
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < 16; p++)
                for (int q = 0; q < 16; q++) begin
                    tbl_addr = tbl_index(c[0], p[3:0], q[3:0]);
                    tbl_wdata = 5'(p + q + c);
                    tick();
                end
        tbl_we = 0;
        // Latency of a single beat.
        send(32'h3, 32'h4, 1'b0, 33'h7);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("latency_cycles", 33'(n), 33'd8);
        tick();
        drain();
        for (int i = 0; i < 10; i++) send(vec[i].x, vec[i].y, vec[i].s, vec[i].e);
        drain();
        // Back-to-back random beats under a randomly stalling consumer.
        rand_rdy = 1;
        for (int i = 0; i < 20; i++) begin
            x = $urandom;
            y = $urandom;
            s = 1'($urandom_range(0, 1));
            send(x, y, s, {1'b0, x} + {1'b0, (s ? ~y : y)} + 33'(s));
        end
        rand_rdy = 0;
        drain();
        // Write while busy is dropped.
        send(32'h3, 32'h4, 1'b0, 33'h7);
        tbl_we = 1; tbl_addr = 9'd0; tbl_wdata = 5'h1F;
        @(negedge clk);
        check("we_blocks_in_ready", in_ready, 1'b0);
        tick();
        tbl_we = 0;
        drain();
        send(32'h0, 32'h0, 1'b0, 33'h0);
        drain();
        // Idle write corrupts entry 0; carries then alternate between entries 0 and 256.
        tbl_we = 1;
        tick();
        tbl_we = 0;
        send(32'h0, 32'h0, 1'b0, 33'h0_1F1F_1F1F);
        drain();
        @(negedge clk);
        check("err_after_corrupt", err, EXP_ERR);
        tick();
        // Write and operand offered together: write wins, beat goes in next cycle.
        tbl_we = 1; tbl_addr = 9'd0; tbl_wdata = 5'h00;
        in_valid = 1; a = 32'h2; b = 32'h2; sub = 0;
        @(negedge clk);
        check("same_cycle_in_ready", in_ready, 1'b0);
        tick();
        tbl_we = 0;
        @(negedge clk);
        check("accept_after_we", in_ready, 1'b1);
        sb.push_back(33'h4);
        tick();
        in_valid = 0;
        drain();
        send(32'h0, 32'h0, 1'b0, 33'h0);
        drain();
        // Reset with four beats in flight.
        for (int i = 0; i < 4; i++) send(32'(i + 1), 32'(i + 1), 1'b0, 33'(2 * (i + 1)));
        @(negedge clk);
        rst_n = 0;
        sb.delete();
        @(negedge clk);
        rst_n = 1;
        tick();
        @(negedge clk);
        check("post_rst_idle", idle, 1'b1);
        check("post_rst_sum", sum, 33'd0);
        check("post_rst_err", err, 1'b0);
        for (int i = 0; i < 12; i++) begin
            check("post_rst_out_valid", out_valid, 1'b0);
            @(negedge clk);
        end
        tick();
        send(32'h1, 32'h1, 1'b0, 33'h2);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
